// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle light FSM.
// Grants WALK on red-only, then a flashing clearance; latches lamp faults.
module ped_crossing_ctrl #(
    parameter logic [5:0] WALK_TIME  = 6'd20,
    parameter logic [5:0] CLR_TIME   = 6'd8,
    parameter logic [5:0] BLINK_HALF = 6'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red_in,
    input  logic       yellow_in,
    input  logic       green_in,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [5:0] countdown,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_DW, ST_WALK, ST_CLEAR, ST_FAULT
    } state_t;

    state_t     state, state_n;
    logic [5:0] timer, timer_n;
    logic [5:0] blink_cnt, blink_cnt_n;
    logic       blink_ph, blink_ph_n;
    logic       req, req_n;
    logic       s1, s2, s3;
    logic       press;
    logic [2:0] lamps;
    logic       red_only, red_yellow, illegal;

    assign lamps      = {red_in, yellow_in, green_in};
    assign red_only   = (lamps == 3'b100);
    assign red_yellow = (lamps == 3'b110);
    assign illegal    = !(lamps == 3'b000 || lamps == 3'b100 ||
                          lamps == 3'b110 || lamps == 3'b001 ||
                          lamps == 3'b010);
    assign press      = s2 & ~s3;

    // Button synchronizer plus edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ped_btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // State, timer, blink and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_DW;
            timer     <= 6'd0;
            blink_cnt <= 6'd0;
            blink_ph  <= 1'b1;
            req       <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
            req       <= req_n;
        end
    end

    // Next-state: illegal lamps win, exit at zero beats decrement
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        blink_cnt_n = blink_cnt;
        blink_ph_n  = blink_ph;
        req_n       = req | press;
        if (illegal || state == ST_FAULT) begin
            state_n = ST_FAULT;
            req_n   = 1'b0;
        end else begin
            case (state)
                ST_DW: begin
                    if (req && red_only) begin
                        state_n = ST_WALK;
                        timer_n = WALK_TIME - 6'd1;
                        req_n   = press;
                    end
                end
                ST_WALK: begin
                    if (green_in) begin
                        state_n = ST_DW;
                    end else if (red_yellow || timer == 6'd0) begin
                        state_n     = ST_CLEAR;
                        timer_n     = CLR_TIME - 6'd1;
                        blink_cnt_n = 6'd0;
                        blink_ph_n  = 1'b1;
                    end else begin
                        timer_n = timer - 6'd1;
                    end
                end
                ST_CLEAR: begin
                    if (blink_cnt == BLINK_HALF - 6'd1) begin
                        blink_cnt_n = 6'd0;
                        blink_ph_n  = ~blink_ph;
                    end else begin
                        blink_cnt_n = blink_cnt + 6'd1;
                    end
                    if (green_in || timer == 6'd0) begin
                        state_n = ST_DW;
                    end else begin
                        timer_n = timer - 6'd1;
                    end
                end
                default: begin
                    state_n = ST_FAULT;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        walk        = (state == ST_WALK);
        fault       = (state == ST_FAULT);
        req_pending = req;
        countdown   = 6'd0;
        dont_walk   = 1'b1;
        if (state == ST_WALK) begin
            dont_walk = 1'b0;
            countdown = timer;
        end else if (state == ST_CLEAR) begin
            dont_walk = blink_ph;
            countdown = timer;
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: a cycle model queues the expected
// outputs for each driven edge; tasks pop and compare after the edge.
module tb_ped_crossing_ctrl;

    localparam int WT = 20;
    localparam int CT = 8;
    localparam int BH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red_in = 1'b0, yellow_in = 1'b0, green_in = 1'b0;
    logic       ped_btn = 1'b0;
    logic       walk, dont_walk, req_pending, fault;
    logic [5:0] countdown;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    ped_crossing_ctrl #(
        .WALK_TIME(6'd20), .CLR_TIME(6'd8), .BLINK_HALF(6'd2)
    ) dut (
        .clk(clk), .rst(rst),
        .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in),
        .ped_btn(ped_btn),
        .walk(walk), .dont_walk(dont_walk),
        .req_pending(req_pending), .countdown(countdown),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // model state: 0 dont-walk, 1 walk, 2 clear, 3 fault
    int       m_st = 0;
    int       m_t = 0;
    int       m_k = 0;
    logic     m_req = 0, m_s1 = 0, m_s2 = 0, m_s3 = 0;

    function automatic void model_step();
        logic p;
        logic [2:0] c;
        if (rst) begin
            m_st = 0; m_t = 0; m_k = 0; m_req = 0;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
            return;
        end
        p = m_s2 & ~m_s3;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = ped_btn;
        c = {red_in, yellow_in, green_in};
        if (m_st == 3 || !(c inside {3'b000, 3'b100, 3'b110,
                                     3'b001, 3'b010})) begin
            m_st = 3; m_req = 0;
            return;
        end
        if (m_st == 0) begin
            if (m_req && c == 3'b100) begin
                m_st = 1; m_t = WT - 1; m_req = p;
            end else m_req = m_req | p;
        end else if (m_st == 1) begin
            m_req = m_req | p;
            if (green_in) m_st = 0;
            else if (c == 3'b110 || m_t == 0) begin
                m_st = 2; m_t = CT - 1; m_k = 0;
            end else m_t = m_t - 1;
        end else begin
            m_req = m_req | p;
            m_k = m_k + 1;
            if (green_in || m_t == 0) m_st = 0;
            else m_t = m_t - 1;
        end
    endfunction

    function automatic logic [9:0] model_out();
        logic dw;
        logic [5:0] cd;
        dw = (m_st == 1) ? 1'b0 :
             (m_st == 2) ? (((m_k / BH) % 2) == 0) : 1'b1;
        cd = (m_st == 1 || m_st == 2) ? 6'(m_t) : 6'd0;
        return {m_st == 1, dw, m_req, m_st == 3, cd};
    endfunction

    function automatic logic [9:0] obs();
        return {walk, dont_walk, req_pending, fault, countdown};
    endfunction

    task automatic apply(input logic rs, input logic [2:0] l,
                         input logic b);
        rst = rs;
        {red_in, yellow_in, green_in} = l;
        ped_btn = b;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 3'b100, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL reset[%0d] got %b want %b", i, obs(), e);
            end
        end
        n_cmp++;
        if (obs() !== 10'b01_0000_0000) begin
            n_err++;
            $display("FAIL reset_vals got %b want %b",
                     obs(), 10'b01_0000_0000);
        end
    endtask

    task automatic test_basic_walk();
        int wc;
        logic [7:0] pat;
        wc = 0; pat = 8'h0;
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 3'b100, i == 4);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL basic[%0d] got %b want %b", i, obs(), e);
            end
            if (walk) wc++;
            if (i >= 27 && i <= 34) pat = {pat[6:0], dont_walk};
            if (i == 5) begin
                n_cmp++;
                if (req_pending !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_early got %b want 0", req_pending);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (req_pending !== 1'b1) begin
                    n_err++;
                    $display("FAIL req_latency got %b want 1", req_pending);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if ({walk, countdown} !== {1'b1, 6'd19}) begin
                    n_err++;
                    $display("FAIL grant got w=%b cd=%0d want w=1 cd=19",
                             walk, countdown);
                end
            end
        end
        n_cmp++;
        if (wc != 20) begin
            n_err++;
            $display("FAIL walk_len got %0d want 20", wc);
        end
        n_cmp++;
        if (pat !== 8'b1100_1100) begin
            n_err++;
            $display("FAIL blink got %b want 11001100", pat);
        end
        n_cmp++;
        if ({walk, dont_walk, req_pending} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_end got %b want 010",
                     {walk, dont_walk, req_pending});
        end
    endtask

    task automatic test_green_cut();
        logic [2:0] l;
        int at10;
        at10 = -1;
        for (int i = 0; i < 30; i++) begin
            l = (i < 8) ? 3'b001 : 3'b100;
            if (at10 >= 0 && i > at10) l = 3'b110;
            if (at10 >= 0 && i > at10 + 3) l = 3'b001;
            apply(1'b0, l, i == 1);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL cut[%0d] got %b want %b", i, obs(), e);
            end
            if (i == 7) begin
                n_cmp++;
                if ({walk, req_pending} !== 2'b01) begin
                    n_err++;
                    $display("FAIL green_hold got %b want 01",
                             {walk, req_pending});
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (walk !== 1'b1) begin
                    n_err++;
                    $display("FAIL red_grant got %b want 1", walk);
                end
            end
            if (at10 >= 0 && i == at10 + 1) begin
                n_cmp++;
                if ({walk, countdown} !== {1'b0, 6'd7}) begin
                    n_err++;
                    $display("FAIL ry_cut got w=%b cd=%0d want w=0 cd=7",
                             walk, countdown);
                end
            end
            if (at10 < 0 && walk && countdown == 6'd10) at10 = i;
        end
        n_cmp++;
        if ({walk, dont_walk} !== 2'b01) begin
            n_err++;
            $display("FAIL green_clear got %b want 01", {walk, dont_walk});
        end
    endtask

    task automatic test_back_to_back();
        int walks;
        logic pw;
        walks = 0; pw = 1'b0;
        for (int i = 0; i < 70; i++) begin
            apply(1'b0, 3'b100, i == 0 || i == 12);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL b2b[%0d] got %b want %b", i, obs(), e);
            end
            if (walk && !pw) walks++;
            pw = walk;
        end
        n_cmp++;
        if (walks != 2) begin
            n_err++;
            $display("FAIL b2b_walks got %0d want 2", walks);
        end
    endtask

    task automatic test_fault();
        logic [2:0] l;
        for (int i = 0; i < 14; i++) begin
            l = (i == 5) ? 3'b101 : 3'b100;
            apply(i >= 12, l, i == 0 || i == 8);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL fault[%0d] got %b want %b", i, obs(), e);
            end
            if (i == 11) begin
                n_cmp++;
                if (obs() !== 10'b01_0100_0000) begin
                    n_err++;
                    $display("FAIL fault_sticky got %b want %b",
                             obs(), 10'b01_0100_0000);
                end
            end
        end
        n_cmp++;
        if (obs() !== 10'b01_0000_0000) begin
            n_err++;
            $display("FAIL fault_rst got %b want %b",
                     obs(), 10'b01_0000_0000);
        end
    endtask

    task automatic test_btn_reset();
        int walks;
        logic pw;
        walks = 0; pw = 1'b0;
        for (int i = 0; i < 48; i++) begin
            apply(i < 3, 3'b100, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL btnrst[%0d] got %b want %b", i, obs(), e);
            end
            if (walk && !pw) walks++;
            pw = walk;
        end
        n_cmp++;
        if (walks != 1 || req_pending !== 1'b0) begin
            n_err++;
            $display("FAIL btn_once got walks=%0d req=%b want 1/0",
                     walks, req_pending);
        end
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_green_cut();
        test_back_to_back();
        test_fault();
        test_btn_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the vehicle traffic-light FSM. It observes the vehicle red/yellow/green lamp outputs, latches pedestrian button requests, and drives the WALK and DON'T-WALK lamps. WALK is granted only during the vehicle red-only phase, followed by a flashing DON'T-WALK clearance interval. Illegal lamp combinations from the vehicle FSM are flagged and latched as a fault.

## Interface
Parameters:
- WALK_TIME, 6'd20, WALK duration in clk cycles (1..63)
- CLR_TIME, 6'd8, flashing clearance duration in clk cycles (1..63)
- BLINK_HALF, 6'd2, cycles per half-period of the DON'T-WALK flash (1..63)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- red_in  input  1  vehicle red lamp from traffic-light FSM
- yellow_in  input  1  vehicle yellow lamp from traffic-light FSM
- green_in  input  1  vehicle green lamp from traffic-light FSM
- ped_btn  input  1  raw asynchronous pedestrian push-button, active-high
- walk  output  1  WALK lamp
- dont_walk  output  1  DON'T-WALK lamp, steady or flashing
- req_pending  output  1  latched pedestrian request not yet served
- countdown  output  6  remaining cycles in WALK/CLEAR, 0 otherwise
- fault  output  1  sticky illegal-vehicle-lamp flag

## Operation
- Lamp decode from {red_in,yellow_in,green_in}: legal = 000 (idle), 100 (red_only), 110 (red_yellow), 001 (green), 010 (yellow). Any other code is illegal.
- Button path:
  - ped_btn passes through a 2-flop synchronizer s1→s2, then a third flop s3.
  - A press is s2 & ~s3.
  - A press sets req_pending on the next edge.
- States: DONT_WALK, WALK, CLEAR, FAULT. Outputs are Moore decodes of the state plus the blink and timer registers.
- DONT_WALK: walk=0, dont_walk=1, countdown=0.
  - If req_pending=1 and red_only=1: go to WALK, load timer=WALK_TIME-1, clear req_pending.
- WALK: walk=1, dont_walk=0, countdown=timer. Timer decrements by 1 each cycle. Transitions in priority order:
  - green_in=1: go to DONT_WALK.
  - red_yellow=1: go to CLEAR, load timer=CLR_TIME-1.
  - timer==0: go to CLEAR, load timer=CLR_TIME-1.
- CLEAR: walk=0, countdown=timer.
  - Blink counter resets on entry. dont_walk=1 for the first BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating.
  - green_in=1: go to DONT_WALK.
  - timer==0: go to DONT_WALK.
  - red_yellow does not shorten CLEAR.
- FAULT: walk=0, dont_walk=1 steady, fault=1, countdown=0, req_pending held 0. Exits only via rst.
- Priority each edge: rst > illegal code (any state → FAULT) > state rules above.
- Presses that occur during WALK/CLEAR are latched and served at the next red_only phase.

## Timing
- Reset values:
  - state=DONT_WALK
  - walk=0, dont_walk=1, req_pending=0, countdown=0, fault=0
  - s1, s2, s3 = 0, so a button held through reset counts as one press after reset
- Request latency: ped_btn first sampled high at edge k → req_pending=1 after edge k+2. Holding the button produces exactly one press.
- Grant latency: red_only and req_pending both high before edge g → walk=1 and countdown=WALK_TIME-1 after edge g.
- Simultaneous grant and new press: req_pending stays 1.
- Walk length: walk is high for exactly WALK_TIME cycles if not cut short. countdown runs WALK_TIME-1 down to 0, then CLR_TIME-1 down to 0.
- Green or illegal code sampled at edge e → walk=0 after edge e. There is no extra-cycle overlap of walk and vehicle green beyond the FSM's own register delay.
- rst mid-WALK/CLEAR/FAULT → reset values after that edge. Pending request is discarded.
- Timer is 6-bit, loaded only on entry to WALK/CLEAR, and never underflows: the exit at 0 takes precedence over the decrement.

## Test plan
- Reset, then hold lamps 100, pulse ped_btn high for 1 cycle at edge 5 → req_pending=1 after edge 7. walk=1 after edge 8 with countdown=19. Walk lasts 20 cycles, then CLEAR for 8 cycles with dont_walk pattern 1,1,0,0,1,1,0,0. Final state DONT_WALK, req_pending=0.
- Request during lamps 001 → no walk. Switch lamps to 100 → walk=1 one edge later.
- In WALK at countdown=10, lamps go to 110 → next cycle CLEAR with countdown=7. Lamps go to 001 during CLEAR → dont_walk=1 steady, walk=0 the next cycle.
- Press during WALK → req_pending=1 after CLEAR ends. Next red_only phase grants a second walk.
- Lamps 101 for one cycle in any state → fault=1, walk=0, dont_walk=1. Fault stays set through legal codes and presses until rst, after which all outputs return to reset values.
- Hold ped_btn high across the rst deassertion → exactly one request. With red_only present, exactly one walk.
